vga_frame_checker: RTL and testbench
====================================

# vga_frame_checker

Synthesizable VGA sink that consumes the `hsync`/`vsync`/`rgb` stream produced by `vga_timing` and `draw`, and recovers the pixel grid from the sync pulses alone. It reconstructs pixel coordinates and the data-enable signal, then compresses every frame into a CRC-16 signature plus pixel and line counts. This lets benches self-check rendered frames without dumping TIFFs. Timing defaults match the 1024x768 @ 75 MHz mode (1328x806 total) used across the design.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- V_ACTIVE, 768, visible lines per frame
- H_TOTAL, 1328, clocks per line (line-length check)
- H_BACK, 144, clocks from hsync deassert to first active pixel
- V_BACK, 29, hsync-deassert edges from vsync deassert to first active line
- SYNC_ACTIVE, 1'b1, asserted level of hsync and vsync

Ports:
- clk  in  1  pixel clock, 75 MHz
- rst  in  1  reset; one clock; reset is synchronous and active-high
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- rgb  in  12  pixel {r,g,b}, 4 bits each
- locked  out  1  frame alignment achieved
- de  out  1  decoded active-pixel strobe
- x  out  11  active column 0..H_ACTIVE-1; 0 when de=0
- y  out  11  active row 0..V_ACTIVE-1; 0 when de=0
- pix  out  12  rgb aligned with de; 0 when de=0
- frame_done  out  1  one-cycle pulse; frame_* outputs updated
- frame_crc  out  16  CRC of the last complete frame
- frame_pixels  out  21  de count of the last complete frame
- frame_lines  out  11  hsync-deassert edges in the last complete frame
- err  out  1  sticky protocol error

## Operation
- Input stage: hsync, vsync and rgb are registered into s1, then s2. An hsync edge (hs_e) is s2 asserted and s1 deasserted; an vsync deassert edge (vs_e) is detected the same way. A vsync assert edge (vs_a) is s2 deasserted and s1 asserted.
- hpos (11 b): cleared to 0 on hs_e; otherwise increments, saturating at 2047.
- vpos (11 b): cleared to 0 on vs_e; otherwise increments on hs_e, saturating. If hs_e and vs_e occur in the same cycle, vs_e wins and the hs_e is not counted.
- Active region: hpos in [H_BACK, H_BACK+H_ACTIVE-1] and vpos in [V_BACK, V_BACK+V_ACTIVE-1]. Then x = hpos-H_BACK and y = vpos-V_BACK.
- FSM has two states:
  - SEEK: stays here until vs_e, then moves to LOCKED. No frame_done, no err updates.
  - LOCKED: runs until rst. Sync irregularities only set err; they never drop lock.
- de is forced to 0 in SEEK.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final xor.
  - Each de pixel shifts in its 12 rgb bits, MSB (r[3]) first, in a single cycle.
  - The running CRC, pixel count and line count reinit on vs_e.
- On vs_a in LOCKED:
  - frame_done pulses.
  - frame_crc, frame_pixels and frame_lines latch the running values and hold until the next frame_done.
- err sets, sticky until rst, in LOCKED when either:
  - the clocks between two consecutive hs_e differ from H_TOTAL (checked only after the first hs_e since lock), or
  - frame_pixels latched at frame_done differs from H_ACTIVE*V_ACTIVE.

## Timing
- Reset values: every output is 0. The FSM is in SEEK; hpos, vpos, CRC and counters are cleared.
- rst mid-frame: returns to SEEK. The next frame_done comes only after a full vs_e→vs_a interval.
- Latency: de/x/y/pix are registered outputs for the input sample taken 3 clocks earlier (s1, s2, output register). frame_done and the latched values appear in the same cycle, 3 clocks after the vsync assert sample.
- With the default vga_timing: frame_lines=800 and frame_pixels=786432. The first de of a frame has x=0,y=0; the last has x=1023,y=767.
- The CRC update must close at 75 MHz. It is a combinational 12-bit unroll feeding one register.

## Test plan
- Reset: hold rst for 3 cycles with random inputs → every output 0 and locked=0, checked each cycle.
- Lock and counts: drive vga_timing with rgb=12'hF00 constant → locked rises 3 clocks after the first vsync deassert; the first frame_done gives frame_pixels=786432, frame_lines=800, err=0; frame_crc equals the bench's reference model.
- Coordinates: scoreboard every de against vga_timing hcount/vcount delayed 3 clocks → x/y match throughout; first (0,0), last (1023,767), no de outside the active window.
- Repeatability and sensitivity: two identical frames → equal frame_crc. Flip one pixel (x=512,y=384) to 12'h0F0 in the third frame → frame_crc changes; frame_pixels is unchanged.
- Line error: shorten one line to 1327 clocks → err=1 from the following hs_e and stays 1 across later good frames; locked stays 1.
- Reset mid-frame: assert rst at line 400 → no frame_done at the next vsync assert; the first frame_done arrives one full frame later with correct values.

Source files
------------

// File: rtl/vga_frame_checker_if.sv
// VGA sink stream: sync pulses and 12-bit pixel data from the timing/draw path.
interface vga_frame_checker_if;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    modport master (output hsync, output vsync, output rgb);
    modport slave  (input hsync, input vsync, input rgb);
endinterface

// File: rtl/vga_frame_checker.sv
// Recovers the pixel grid from hsync/vsync, then folds each frame
// into a CRC-16 signature with pixel and line counts.
module vga_frame_checker #(
    parameter int   H_ACTIVE    = 1024,
    parameter int   V_ACTIVE    = 768,
    parameter int   H_TOTAL     = 1328,
    parameter int   H_BACK      = 144,
    parameter int   V_BACK      = 29,
    parameter logic SYNC_ACTIVE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    vga_frame_checker_if.slave vid,
    output logic               locked,
    output logic               de,
    output logic [10:0]        x,
    output logic [10:0]        y,
    output logic [11:0]        pix,
    output logic               frame_done,
    output logic [15:0]        frame_crc,
    output logic [20:0]        frame_pixels,
    output logic [10:0]        frame_lines,
    output logic               err
);

    localparam logic [10:0] H_LO    = 11'(H_BACK);
    localparam logic [10:0] H_HI    = 11'(H_BACK + H_ACTIVE - 1);
    localparam logic [10:0] V_LO    = 11'(V_BACK);
    localparam logic [10:0] V_HI    = 11'(V_BACK + V_ACTIVE - 1);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] POS_MAX = 11'h7FF;
    localparam logic [20:0] N_PIX   = 21'(H_ACTIVE * V_ACTIVE);

    typedef enum logic {SEEK, LOCKED} state_t;

    state_t      state;
    logic        hs1, hs2, vs1, vs2;
    logic [11:0] rgb1, rgb2;
    logic        hs_e, vs_e, vs_a;
    logic [10:0] hpos, vpos;
    logic        act;
    logic [15:0] crc, crc_nx;
    logic [20:0] pcnt;
    logic        vs_a_q;
    logic        hs_seen;
    logic        line_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs1  <= ~SYNC_ACTIVE;
            hs2  <= ~SYNC_ACTIVE;
            vs1  <= ~SYNC_ACTIVE;
            vs2  <= ~SYNC_ACTIVE;
            rgb1 <= '0;
            rgb2 <= '0;
        end else begin
            hs1  <= vid.hsync;
            hs2  <= hs1;
            vs1  <= vid.vsync;
            vs2  <= vs1;
            rgb1 <= vid.rgb;
            rgb2 <= rgb1;
        end
    end

    assign hs_e = (hs2 == SYNC_ACTIVE) && (hs1 != SYNC_ACTIVE);
    assign vs_e = (vs2 == SYNC_ACTIVE) && (vs1 != SYNC_ACTIVE);
    assign vs_a = (vs2 != SYNC_ACTIVE) && (vs1 == SYNC_ACTIVE);

    // hpos/vpos describe the sample held in s2
    always_ff @(posedge clk) begin
        if (rst) begin
            hpos <= '0;
            vpos <= '0;
        end else begin
            if (hs_e)
                hpos <= '0;
            else if (hpos != POS_MAX)
                hpos <= hpos + 11'd1;
            if (vs_e)
                vpos <= '0;
            else if (hs_e && vpos != POS_MAX)
                vpos <= vpos + 11'd1;
        end
    end

    assign act = (state == LOCKED)
               && hpos >= H_LO && hpos <= H_HI
               && vpos >= V_LO && vpos <= V_HI;

    always_ff @(posedge clk) begin
        if (rst) begin
            de  <= 1'b0;
            x   <= '0;
            y   <= '0;
            pix <= '0;
        end else begin
            de  <= act;
            x   <= act ? hpos - H_LO : 11'd0;
            y   <= act ? vpos - V_LO : 11'd0;
            pix <= act ? rgb2 : 12'd0;
        end
    end

    always_comb begin
        crc_nx = crc;
        for (int i = 11; i >= 0; i--) begin
            if (crc_nx[15] ^ pix[i])
                crc_nx = {crc_nx[14:0], 1'b0} ^ 16'h1021;
            else
                crc_nx = {crc_nx[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc  <= 16'hFFFF;
            pcnt <= '0;
        end else if (vs_e) begin
            crc  <= 16'hFFFF;
            pcnt <= '0;
        end else if (de) begin
            crc  <= crc_nx;
            pcnt <= pcnt + 21'd1;
        end
    end

    // vs_a and line errors are delayed one stage to line up with de
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEEK;
            locked       <= 1'b0;
            frame_done   <= 1'b0;
            frame_crc    <= '0;
            frame_pixels <= '0;
            frame_lines  <= '0;
            err          <= 1'b0;
            vs_a_q       <= 1'b0;
            hs_seen      <= 1'b0;
            line_bad     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            line_bad   <= 1'b0;
            vs_a_q     <= vs_a;
            locked     <= (state == LOCKED);
            unique case (state)
                SEEK: begin
                    if (vs_e)
                        state <= LOCKED;
                end
                LOCKED: begin
                    if (hs_e) begin
                        hs_seen  <= 1'b1;
                        line_bad <= hs_seen && (hpos != H_LAST);
                    end
                    if (line_bad)
                        err <= 1'b1;
                    if (vs_a_q) begin
                        frame_done   <= 1'b1;
                        frame_crc    <= crc;
                        frame_pixels <= pcnt;
                        frame_lines  <= vpos;
                        if (pcnt != N_PIX)
                            err <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker on a scaled-down VGA mode (30x15 total).
module tb_vga_frame_checker;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HSY = 4;
    localparam int HBP = 6;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VSY + VBP;

    typedef struct packed {
        logic        locked;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] pix;
        logic        fd;
        logic [15:0] fcrc;
        logic [20:0] fpix;
        logic [10:0] flines;
        logic        err;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_frame_checker_if vid ();

    logic        locked, de, frame_done, err;
    logic [10:0] x, y, frame_lines;
    logic [11:0] pix;
    logic [15:0] frame_crc;
    logic [20:0] frame_pixels;

    vga_frame_checker #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT),
        .H_BACK(HBP), .V_BACK(VBP), .SYNC_ACTIVE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .vid(vid),
        .locked(locked), .de(de), .x(x), .y(y), .pix(pix),
        .frame_done(frame_done), .frame_crc(frame_crc),
        .frame_pixels(frame_pixels), .frame_lines(frame_lines),
        .err(err)
    );

    int checks = 0;
    int passed = 0;

    obs_t exp_q[$];

    // behavioural model state, indexed by input sample
    int          n = 0;
    bit          m_lock, m_pv, m_phs, m_pvs, m_err;
    int          m_last = -1;
    int          m_lines, m_fpix, m_flines;
    logic [15:0] m_fcrc;
    logic [11:0] m_q[$];
    logic [15:0] m_hist[$];

    logic [15:0] fd_crc[$];
    logic [20:0] fd_pix[$];
    logic [10:0] fd_lines[$];
    logic        fd_err[$];
    logic        fd_locked[$];
    bit          seen_de = 1'b0;
    logic [10:0] fx, fy, lx, ly;

    function automatic logic [15:0] crc_bits(input bit b[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) begin
            bit fb = c[15] ^ b[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_pixels(input logic [11:0] q[$]);
        bit b[$];
        foreach (q[i])
            for (int k = 11; k >= 0; k--) b.push_back(q[i][k]);
        return crc_bits(b);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s got=%0h want=%0h", nm, got, want);
    endtask

    task automatic step(bit r, bit hs, bit vs, logic [11:0] c, int hc, int vc);
        obs_t e;
        bit   hde, vde, vas;
        e = '0;
        if (r) begin
            if (exp_q.size() >= 1) exp_q[exp_q.size()-1] = '0;
            if (exp_q.size() >= 2) exp_q[exp_q.size()-2] = '0;
            exp_q.push_back(e);
            m_lock = 0; m_pv = 0; m_err = 0; m_last = -1;
            m_lines = 0; m_fpix = 0; m_flines = 0; m_fcrc = '0;
            m_q.delete();
            n++;
            return;
        end
        hde = m_pv && m_phs && !hs;
        vde = m_pv && m_pvs && !vs;
        vas = m_pv && !m_pvs && vs;
        if (vas && m_lock) begin
            m_fcrc   = crc_pixels(m_q);
            m_fpix   = m_q.size();
            m_flines = m_lines;
            if (m_fpix != HA * VA) m_err = 1;
            m_hist.push_back(m_fcrc);
            e.fd = 1'b1;
        end
        if (hde && m_lock) begin
            if (m_last >= 0 && n - m_last != HT) m_err = 1;
            m_last = n;
        end
        if (vde) begin
            m_lock = 1;
            m_q.delete();
            m_lines = 0;
        end else if (hde) begin
            m_lines++;
        end
        e.locked = m_lock;
        e.de     = m_lock && hc < HA && vc < VA;
        if (e.de) begin
            e.x   = 11'(hc);
            e.y   = 11'(vc);
            e.pix = c;
            m_q.push_back(c);
        end
        e.fcrc   = m_fcrc;
        e.fpix   = 21'(m_fpix);
        e.flines = 11'(m_flines);
        e.err    = m_err;
        m_pv  = 1; m_phs = hs; m_pvs = vs;
        n++;
        exp_q.push_back(e);
    endtask

    task automatic drive(bit r, bit hs, bit vs, logic [11:0] c, int hc, int vc);
        @(posedge clk);
        #1;
        rst       = r;
        vid.hsync = hs;
        vid.vsync = vs;
        vid.rgb   = c;
        step(r, hs, vs, c, hc, vc);
    endtask

    // outputs for a sample appear three clocks after it is driven
    initial begin
        obs_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 4) begin
                e   = exp_q.pop_front();
                got = {locked, de, x, y, pix, frame_done, frame_crc,
                       frame_pixels, frame_lines, err};
                checks++;
                if (got === e) passed++;
                else $display("FAIL cyc t=%0t got=%h want=%h", $time, got, e);
                if (de && !seen_de) begin
                    fx = x; fy = y; seen_de = 1'b1;
                end
                if (de && fd_crc.size() == 0) begin
                    lx = x; ly = y;
                end
                if (frame_done) begin
                    fd_crc.push_back(frame_crc);
                    fd_pix.push_back(frame_pixels);
                    fd_lines.push_back(frame_lines);
                    fd_err.push_back(err);
                    fd_locked.push_back(locked);
                end
            end
        end
    end

    initial begin
        bit          hs, vs, r;
        logic [11:0] c;
        bit          pin[$];
        string       s = "123456789";

        vid.hsync = 1'b0;
        vid.vsync = 1'b0;
        vid.rgb   = '0;

        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'($urandom), 1'($urandom), 12'($urandom), 0, 0);

        for (int f = 0; f < 9; f++)
            for (int vc = 0; vc < VT; vc++)
                for (int hc = 0; hc < HT; hc++) begin
                    if (f == 4 && vc == 2 && hc == HA + HFP - 1) continue;
                    hs = hc >= HA + HFP && hc < HA + HFP + HSY;
                    vs = vc >= VA + VFP && vc < VA + VFP + VSY;
                    r  = f == 6 && vc == 4 && hc == 5;
                    c  = 12'h000;
                    if (hc < HA && vc < VA)
                        c = (f == 3 && vc == VA / 2 && hc == HA / 2) ? 12'h0F0 : 12'hF00;
                    drive(r, hs, vs, c, hc, vc);
                end

        repeat (4) @(negedge clk);

        for (int i = 0; i < s.len(); i++)
            for (int k = 7; k >= 0; k--) pin.push_back(s[i][k]);
        chk("crc_ref_pin", 32'(crc_bits(pin)), 32'h29B1);

        chk("frame_done_count", 32'(fd_crc.size()), 7);
        while (fd_crc.size() < 7) begin
            fd_crc.push_back('0);
            fd_pix.push_back('0);
            fd_lines.push_back('0);
            fd_err.push_back(1'b0);
            fd_locked.push_back(1'b0);
        end
        chk("f1_pixels", 32'(fd_pix[0]), 128);
        chk("f1_lines", 32'(fd_lines[0]), 13);
        chk("f1_err", 32'(fd_err[0]), 0);
        chk("first_de_x", 32'(fx), 0);
        chk("first_de_y", 32'(fy), 0);
        chk("last_de_x", 32'(lx), 15);
        chk("last_de_y", 32'(ly), 7);
        chk("crc_repeat", 32'(fd_crc[1]), 32'(fd_crc[0]));
        chk("crc_sensitive", 32'(fd_crc[2] != fd_crc[0]), 1);
        chk("f3_pixels", 32'(fd_pix[2]), 128);
        chk("model_crc_sensitive", 32'(m_hist.size() > 2 && m_hist[2] != m_hist[0]), 1);
        chk("line_err_set", 32'(fd_err[3]), 1);
        chk("line_err_sticky", 32'(fd_err[4]), 1);
        chk("lock_kept", 32'(fd_locked[4]), 1);
        chk("post_rst_pixels", 32'(fd_pix[5]), 128);
        chk("post_rst_lines", 32'(fd_lines[5]), 13);
        chk("post_rst_err", 32'(fd_err[5]), 0);
        chk("post_rst_crc", 32'(fd_crc[5]), 32'(fd_crc[0]));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
